// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the next-PC scheduler.
package pc_ctrl_pkg;

  localparam int unsigned PCC_ADDR_W = 32;
  localparam logic [PCC_ADDR_W-1:0] INSTR_ADDR_INI = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCC_ST_RUN  = 2'd0,
    PCC_ST_PEND = 2'd1,
    PCC_ST_HALT = 2'd2
  } pcc_state_e;

  typedef enum logic {
    PCC_SRC_BR   = 1'b0,
    PCC_SRC_TRAP = 1'b1
  } pcc_src_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// Front-end control bundle between the redirect sources, PC register and pc_ctrl.
// Perf counter signals exist only when PC_CTRL_PERF_EN is defined.
interface pc_ctrl_if #(
  parameter int unsigned ADDR_W = pc_ctrl_pkg::PCC_ADDR_W
);
  import pc_ctrl_pkg::*;

  logic              ifu_ready;
  logic              stall_req;
  logic              br_redirect;
  logic [ADDR_W-1:0] br_target;
  logic              trap_redirect;
  logic [ADDR_W-1:0] trap_target;
  logic              wfi_req;
  logic              wake;

  logic              hold_n;
  logic              jmp_en;
  logic [ADDR_W-1:0] jmp_to;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              pend_busy;
  pcc_src_e          pend_src;
`ifdef PC_CTRL_PERF_EN
  logic [ADDR_W-1:0] perf_stall_cyc;
  logic [ADDR_W-1:0] perf_redir_cnt;
`endif

  modport slave (
    input  ifu_ready, stall_req, br_redirect, br_target,
           trap_redirect, trap_target, wfi_req, wake,
    output hold_n, jmp_en, jmp_to, flush_if_id, flush_id_ex,
           pend_busy, pend_src
`ifdef PC_CTRL_PERF_EN
           , perf_stall_cyc, perf_redir_cnt
`endif
  );

  modport master (
    output ifu_ready, stall_req, br_redirect, br_target,
           trap_redirect, trap_target, wfi_req, wake,
    input  hold_n, jmp_en, jmp_to, flush_if_id, flush_id_ex,
           pend_busy, pend_src
`ifdef PC_CTRL_PERF_EN
           , perf_stall_cyc, perf_redir_cnt
`endif
  );

endinterface

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect select: trap beats branch, target word-aligned.
module pc_redirect_arb
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = PCC_ADDR_W
) (
  input  logic              trap_redirect_i,
  input  logic [ADDR_W-1:0] trap_target_i,
  input  logic              br_redirect_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic              sel_valid_c,
  output pcc_src_e          sel_src_c,
  output logic [ADDR_W-1:0] sel_target_c
);

  logic [ADDR_W-1:0] raw_target;

  always_comb begin
    sel_valid_c  = trap_redirect_i | br_redirect_i;
    sel_src_c    = trap_redirect_i ? PCC_SRC_TRAP : PCC_SRC_BR;
    raw_target   = trap_redirect_i ? trap_target_i : br_target_i;
    sel_target_c = {raw_target[ADDR_W-1:2], 2'b00};
  end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC scheduler: redirect arbitration, stall, parked redirect and WFI idle.
// Define PC_CTRL_PERF_EN to add the stall-cycle and applied-redirect counters.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = PCC_ADDR_W
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_ctrl_if.slave   bus
);

  pcc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  pcc_src_e          pend_src_q, pend_src_d;

  logic              sel_valid;
  pcc_src_e          sel_src;
  logic [ADDR_W-1:0] sel_target;

  logic              hold_n_c;
  logic              jmp_en_c;
  logic [ADDR_W-1:0] jmp_to_c;
  logic              flush_if_id_c;
  logic              flush_id_ex_c;

  pc_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
    .trap_redirect_i (bus.trap_redirect),
    .trap_target_i   (bus.trap_target),
    .br_redirect_i   (bus.br_redirect),
    .br_target_i     (bus.br_target),
    .sel_valid_c     (sel_valid),
    .sel_src_c       (sel_src),
    .sel_target_c    (sel_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PCC_ST_RUN;
      pend_target_q <= '0;
      pend_src_q    <= PCC_SRC_BR;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      pend_src_q    <= pend_src_d;
    end
  end

  // Next state and front-end controls; in HALT/PEND only a trap can redirect.
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pend_src_d    = pend_src_q;
    hold_n_c      = 1'b0;
    jmp_en_c      = 1'b0;
    jmp_to_c      = sel_target;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;

    case (state_q)
      PCC_ST_RUN: begin
        if (sel_valid) begin
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
          if (bus.ifu_ready) begin
            jmp_en_c = 1'b1;
            hold_n_c = 1'b1;
          end else begin
            pend_target_d = sel_target;
            pend_src_d    = sel_src;
            state_d       = PCC_ST_PEND;
          end
        end else if (bus.wfi_req && !bus.wake) begin
          flush_if_id_c = 1'b1;
          state_d       = PCC_ST_HALT;
        end else begin
          hold_n_c = bus.ifu_ready & ~bus.stall_req;
        end
      end

      PCC_ST_PEND: begin
        jmp_en_c      = 1'b1;
        flush_if_id_c = 1'b1;
        hold_n_c      = bus.ifu_ready;
        jmp_to_c      = bus.trap_redirect ? sel_target : pend_target_q;
        if (bus.trap_redirect) begin
          pend_target_d = sel_target;
          pend_src_d    = PCC_SRC_TRAP;
        end
        if (bus.ifu_ready) begin
          state_d = PCC_ST_RUN;
        end
      end

      PCC_ST_HALT: begin
        flush_if_id_c = 1'b1;
        if (bus.trap_redirect) begin
          flush_id_ex_c = 1'b1;
          if (bus.ifu_ready) begin
            jmp_en_c = 1'b1;
            hold_n_c = 1'b1;
            state_d  = PCC_ST_RUN;
          end else begin
            pend_target_d = sel_target;
            pend_src_d    = PCC_SRC_TRAP;
            state_d       = PCC_ST_PEND;
          end
        end else if (bus.wake) begin
          state_d = PCC_ST_RUN;
        end
      end

      default: begin
        state_d = PCC_ST_RUN;
      end
    endcase
  end

  // Reset forces the PC to hold and kills both pipeline registers.
  always_comb begin
    bus.hold_n      = rst_n & hold_n_c;
    bus.jmp_en      = rst_n & jmp_en_c;
    bus.jmp_to      = jmp_to_c;
    bus.flush_if_id = ~rst_n | flush_if_id_c;
    bus.flush_id_ex = ~rst_n | flush_id_ex_c;
    bus.pend_busy   = rst_n & (state_q == PCC_ST_PEND);
    bus.pend_src    = pend_src_q;
  end

`ifdef PC_CTRL_PERF_EN
  logic [ADDR_W-1:0] perf_stall_q, perf_redir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (!hold_n_c) begin
        perf_stall_q <= perf_stall_q + ADDR_W'(1);
      end
      if (jmp_en_c && hold_n_c) begin
        perf_redir_q <= perf_redir_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    bus.perf_stall_cyc = perf_stall_q;
    bus.perf_redir_cnt = perf_redir_q;
  end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized run against a reference model.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  localparam int unsigned AW = PCC_ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_ctrl_if #(.ADDR_W(AW)) bus ();
  pc_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // PC register driven by the DUT controls
  logic [AW-1:0] pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= INSTR_ADDR_INI;
    else if (bus.hold_n) pc_q <= bus.jmp_en ? bus.jmp_to : pc_q + AW'(4);
  end

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  bit          m_parked;
  bit          m_halted;
  logic [AW-1:0] m_tgt;
  logic [AW-1:0] m_stall;
  logic [AW-1:0] m_redir;

  logic [36:0] obs;
  logic [36:0] exp;

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  function automatic logic [36:0] obs_vec();
    return {bus.hold_n, bus.jmp_en, (bus.jmp_en ? bus.jmp_to : AW'(0)),
            bus.flush_if_id, bus.flush_id_ex, bus.pend_busy};
  endfunction

  function automatic logic [36:0] exp_vec(input bit h, input bit j, input logic [AW-1:0] t,
                                          input bit fi, input bit fe, input bit pb);
    return {h, j, (j ? t : AW'(0)), fi, fe, pb};
  endfunction

  task automatic drive(input bit ifr, input bit st, input bit br, input logic [AW-1:0] bt,
                       input bit tr, input logic [AW-1:0] tt, input bit wfi, input bit wk);
    @(negedge clk);
    bus.ifu_ready     = ifr;
    bus.stall_req     = st;
    bus.br_redirect   = br;
    bus.br_target     = bt;
    bus.trap_redirect = tr;
    bus.trap_target   = tt;
    bus.wfi_req       = wfi;
    bus.wake          = wk;
    #1;
  endtask

  task automatic idle(input bit ifr);
    drive(ifr, 1'b0, 1'b0, AW'(0), 1'b0, AW'(0), 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ifu_ready = 1'b1; bus.stall_req = 1'b0; bus.br_redirect = 1'b0; bus.br_target = '0;
    bus.trap_redirect = 1'b0; bus.trap_target = '0; bus.wfi_req = 1'b0; bus.wake = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_parked = 1'b0; m_halted = 1'b0; m_tgt = '0; m_stall = '0; m_redir = '0;
  endtask

  // Expected outputs for the current inputs, and model advance for the coming edge
  task automatic model_eval(output logic [36:0] e);
    bit h, j, fi, fe, pb;
    logic [AW-1:0] t;
    bit redirect;
    h = 0; j = 0; fi = 0; fe = 0; pb = 0; t = '0;
    redirect = m_halted ? bus.trap_redirect : (bus.trap_redirect | bus.br_redirect);
    if (m_parked) begin
      pb = 1; j = 1; fi = 1; h = bus.ifu_ready;
      t = bus.trap_redirect ? align(bus.trap_target) : m_tgt;
      if (bus.trap_redirect) m_tgt = align(bus.trap_target);
      if (bus.ifu_ready) m_parked = 0;
    end else if (redirect) begin
      t = align(bus.trap_redirect ? bus.trap_target : bus.br_target);
      fi = 1; fe = 1; m_halted = 0;
      if (bus.ifu_ready) begin j = 1; h = 1; end
      else begin m_parked = 1; m_tgt = t; end
    end else if (m_halted) begin
      fi = 1;
      if (bus.wake) m_halted = 0;
    end else if (bus.wfi_req && !bus.wake) begin
      fi = 1; m_halted = 1;
    end else begin
      h = bus.ifu_ready & ~bus.stall_req;
    end
    if (!h) m_stall = m_stall + AW'(1);
    if (j && h) m_redir = m_redir + AW'(1);
    e = exp_vec(h, j, t, fi, fe, pb);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ifu_ready = 1'b1; bus.stall_req = 1'b0; bus.br_redirect = 1'b0; bus.br_target = '0;
    bus.trap_redirect = 1'b0; bus.trap_target = '0; bus.wfi_req = 1'b0; bus.wake = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    exp = exp_vec(0, 0, 0, 1, 1, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL reset_outputs: got %h exp %h", obs, exp); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp = exp_vec(1, 0, 0, 0, 0, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL reset_release: got %h exp %h", obs, exp); else n_pass++;
    n_chk++;
    if (pc_q !== INSTR_ADDR_INI) $display("FAIL pc_ini: got %h exp %h", pc_q, INSTR_ADDR_INI); else n_pass++;
    for (int i = 1; i <= 2; i++) begin
      idle(1'b1);
      n_chk++;
      if (pc_q !== INSTR_ADDR_INI + AW'(4 * i))
        $display("FAIL pc_seq: got %h exp %h", pc_q, INSTR_ADDR_INI + AW'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_branch_stall();
    drive(1, 1, 1, 32'h8000_0102, 0, 0, 0, 0);
    exp = exp_vec(1, 1, 32'h8000_0100, 1, 1, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL br_over_stall: got %h exp %h", obs, exp); else n_pass++;
    idle(1'b1);
    n_chk++;
    if (pc_q !== 32'h8000_0100) $display("FAIL br_pc: got %h exp %h", pc_q, 32'h8000_0100); else n_pass++;
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    exp = exp_vec(0, 0, 0, 0, 0, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL stall_no_flush: got %h exp %h", obs, exp); else n_pass++;
  endtask

  task automatic test_pend();
    drive(0, 0, 1, 32'h200, 0, 0, 0, 0);
    exp = exp_vec(0, 0, 0, 1, 1, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL pend_park: got %h exp %h", obs, exp); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      exp = exp_vec(0, 1, 32'h200, 1, 0, 1); obs = obs_vec(); n_chk++;
      if (obs !== exp) $display("FAIL pend_wait%0d: got %h exp %h", i, obs, exp); else n_pass++;
    end
    n_chk++;
    if (bus.pend_src !== PCC_SRC_BR) $display("FAIL pend_src_br: got %0d exp %0d", bus.pend_src, PCC_SRC_BR); else n_pass++;
    idle(1'b1);
    exp = exp_vec(1, 1, 32'h200, 1, 0, 1); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL pend_exit: got %h exp %h", obs, exp); else n_pass++;
    idle(1'b1);
    exp = exp_vec(1, 0, 0, 0, 0, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp || pc_q !== 32'h200) $display("FAIL pend_done: got %h pc %h exp %h pc 200", obs, pc_q, exp); else n_pass++;
  endtask

  task automatic test_pend_overwrite();
    drive(0, 0, 1, 32'h200, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h300, 0, 0, 0, 0);
    exp = exp_vec(0, 1, 32'h200, 1, 0, 1); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL pend_br_ignored: got %h exp %h", obs, exp); else n_pass++;
    drive(0, 0, 0, 0, 1, 32'h100, 0, 0);
    idle(1'b0);
    exp = exp_vec(0, 1, 32'h100, 1, 0, 1); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL pend_trap_overwrite: got %h exp %h", obs, exp); else n_pass++;
    n_chk++;
    if (bus.pend_src !== PCC_SRC_TRAP) $display("FAIL pend_src_trap: got %0d exp %0d", bus.pend_src, PCC_SRC_TRAP); else n_pass++;
    idle(1'b1);
    idle(1'b1);
    n_chk++;
    if (pc_q !== 32'h100) $display("FAIL pend_trap_pc: got %h exp %h", pc_q, 32'h100); else n_pass++;
    // overwrite and exit in the same cycle
    drive(0, 0, 1, 32'h500, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 32'h183, 0, 0);
    exp = exp_vec(1, 1, 32'h180, 1, 0, 1); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL pend_same_cycle: got %h exp %h", obs, exp); else n_pass++;
    idle(1'b1);
    n_chk++;
    if (pc_q !== 32'h180) $display("FAIL pend_same_pc: got %h exp %h", pc_q, 32'h180); else n_pass++;
  endtask

  task automatic test_priority();
    drive(1, 0, 1, 32'h400, 1, 32'h100, 0, 0);
    exp = exp_vec(1, 1, 32'h100, 1, 1, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL trap_priority: got %h exp %h", obs, exp); else n_pass++;
  endtask

  task automatic test_wfi();
    logic [AW-1:0] held;
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    exp = exp_vec(1, 0, 0, 0, 0, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL wfi_with_wake: got %h exp %h", obs, exp); else n_pass++;
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    held = pc_q;
    exp = exp_vec(0, 0, 0, 1, 0, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL wfi_enter: got %h exp %h", obs, exp); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, (i == 2), 32'h900, 0, 0, 0, 0);
      exp = exp_vec(0, 0, 0, 1, 0, 0); obs = obs_vec(); n_chk++;
      if (obs !== exp || pc_q !== held) $display("FAIL halt_hold%0d: got %h pc %h exp %h pc %h", i, obs, pc_q, exp, held); else n_pass++;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    idle(1'b1);
    exp = exp_vec(1, 0, 0, 0, 0, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp || pc_q !== held) $display("FAIL wake_resume: got %h pc %h exp %h pc %h", obs, pc_q, exp, held); else n_pass++;
    idle(1'b1);
    n_chk++;
    if (pc_q !== held + AW'(4)) $display("FAIL wake_pc: got %h exp %h", pc_q, held + AW'(4)); else n_pass++;
    // trap while halted with the fetch bus busy parks it
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 32'h240, 0, 0);
    exp = exp_vec(0, 0, 0, 1, 1, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL halt_trap_park: got %h exp %h", obs, exp); else n_pass++;
    idle(1'b1);
    exp = exp_vec(1, 1, 32'h240, 1, 0, 1); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL halt_trap_apply: got %h exp %h", obs, exp); else n_pass++;
    idle(1'b1);
  endtask

  task automatic test_reset_mid_pend();
    drive(0, 0, 1, 32'h700, 0, 0, 0, 0);
    idle(1'b0);
    exp = exp_vec(0, 1, 32'h700, 1, 0, 1); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL rst_pend_setup: got %h exp %h", obs, exp); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    exp = exp_vec(0, 0, 0, 1, 1, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL rst_pend_async: got %h exp %h", obs, exp); else n_pass++;
    @(negedge clk);
    bus.ifu_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    exp = exp_vec(1, 0, 0, 0, 0, 0); obs = obs_vec(); n_chk++;
    if (obs !== exp) $display("FAIL rst_pend_release: got %h exp %h", obs, exp); else n_pass++;
    idle(1'b1);
    n_chk++;
    if (pc_q !== INSTR_ADDR_INI + AW'(4)) $display("FAIL rst_pend_pc: got %h exp %h", pc_q, INSTR_ADDR_INI + AW'(4)); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            AW'($urandom), ($urandom_range(0, 9) == 0), AW'($urandom),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 4) == 0));
      model_eval(exp);
      obs = obs_vec(); n_chk++;
      if (obs !== exp) begin
        if (errs < 10) $display("FAIL random_cyc%0d: got %h exp %h", i, obs, exp);
        errs++;
      end else n_pass++;
      n_chk++;
      if (bus.jmp_to[1:0] !== 2'b00) $display("FAIL random_align%0d: got %b exp 00", i, bus.jmp_to[1:0]); else n_pass++;
    end
`ifdef PC_CTRL_PERF_EN
    @(negedge clk);
    n_chk++;
    if (bus.perf_stall_cyc !== m_stall) $display("FAIL perf_stall: got %0d exp %0d", bus.perf_stall_cyc, m_stall); else n_pass++;
    n_chk++;
    if (bus.perf_redir_cnt !== m_redir) $display("FAIL perf_redir: got %0d exp %0d", bus.perf_redir_cnt, m_redir); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_branch_stall();
    test_pend();
    test_pend_overwrite();
    test_priority();
    test_wfi();
    test_reset_mid_pend();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
